// File: rtl/accumulator_pkg.sv
// Shared defaults for the histogram combination path. The histogram and the
// pre-merger import these so their window depth and count width agree.
package accumulator_pkg;

    localparam int ACC_WIDTH_DEFAULT        = 16;
    localparam int ACC_DEPTH_DEFAULT        = 7;
    localparam int ACC_CNT_IN_WIDTH_DEFAULT = 4;
    localparam int ACC_CNT_WIDTH_DEFAULT    = 8;

    // True when a window depth / count width combination can be built:
    // at least one window entry, and an output count at least as wide as
    // the input weight so a single sample always fits.
    function automatic bit acc_params_ok(input int depth,
                                         input int cnt_width,
                                         input int cnt_in_width);
        return (depth >= 1) && (cnt_width >= cnt_in_width);
    endfunction

endpackage

// File: rtl/accumulator_pre_merger.sv
// Pre-accumulation stage ahead of the histogram RAM. Samples with the same
// bin value that fall within DEPTH entries of each other are folded into the
// oldest one, so the downstream read-modify-write never sees a bin twice
// within its pipeline depth. Merged counts saturate at CNT_MAX by leaving the
// overflowing duplicate in place; it later heads its own sum, so no weight
// is ever lost.
module accumulator_pre_merger
    import accumulator_pkg::*;
#(
    parameter int WIDTH        = ACC_WIDTH_DEFAULT,
    parameter int DEPTH        = ACC_DEPTH_DEFAULT,
    parameter int CNT_IN_WIDTH = ACC_CNT_IN_WIDTH_DEFAULT,
    parameter int CNT_WIDTH    = ACC_CNT_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    merge_en,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    input  logic [CNT_IN_WIDTH-1:0] s_cnt,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic [CNT_WIDTH-1:0]    m_cnt
);

    if (!acc_params_ok(DEPTH, CNT_WIDTH, CNT_IN_WIDTH)) begin : g_param_check
        $error("accumulator_pre_merger: need DEPTH >= 1 and CNT_WIDTH >= CNT_IN_WIDTH");
    end

    localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    typedef struct packed {
        logic                 vd;
        logic [WIDTH-1:0]     data;
        logic [CNT_WIDTH-1:0] cnt;
    } slot_t;

    // slots[DEPTH] is the newest entry, slots[0] the head about to leave
    slot_t                slots [DEPTH+1];
    logic                 adv;
    logic [CNT_WIDTH-1:0] acc;
    logic [CNT_WIDTH:0]   trial;
    logic [DEPTH:1]       absorb;

    // The window and output register move together; anything else freezes
    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

    // Scan the window oldest-first, folding same-bin entries into the head while the sum fits
    always_comb begin
        acc    = slots[0].cnt;
        trial  = '0;
        absorb = '0;
        if (merge_en && slots[0].vd) begin
            for (int i = 1; i <= DEPTH; i++) begin
                trial = {1'b0, acc} + {1'b0, slots[i].cnt};
                if (slots[i].vd && (slots[i].data == slots[0].data) && (trial <= CNT_MAX)) begin
                    acc       = trial[CNT_WIDTH-1:0];
                    absorb[i] = 1'b1;
                end
            end
        end
    end

    // Shift the window, invalidating entries that were folded into the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '{vd:   slots[i+1].vd && !absorb[i+1],
                              data: slots[i+1].data,
                              cnt:  slots[i+1].cnt};
            end
            slots[DEPTH] <= '{vd:   s_valid && (s_cnt != '0),
                              data: s_data,
                              cnt:  CNT_WIDTH'(s_cnt)};
        end
    end

    // Register the head together with its merged count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_cnt   <= '0;
        end else if (adv) begin
            m_valid <= slots[0].vd;
            m_data  <= slots[0].data;
            m_cnt   <= merge_en ? acc : slots[0].cnt;
        end
    end

endmodule

// File: tb/tb_accumulator_pre_merger.sv
// Self-checking bench for accumulator_pre_merger with a short window and a
// narrow count so that merging, saturation and window edges are easy to hit.
module tb_accumulator_pre_merger;

    localparam int W    = 16;
    localparam int D    = 3;
    localparam int CI   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          merge_en;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic [CI-1:0] s_cnt;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [CW-1:0] m_cnt;

    accumulator_pre_merger #(
        .WIDTH(W), .DEPTH(D), .CNT_IN_WIDTH(CI), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .merge_en(merge_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_cnt(s_cnt),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_cnt(m_cnt)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int errors = 0;
    int checks = 0;

    // Every slot entry (one per advancing cycle) and every handshaked output
    bit      posV [$];
    int      posD [$];
    int      posC [$];
    int      obsD [$];
    int      obsC [$];
    int      expD [$];
    int      expC [$];
    longint  sumIn;
    longint  sumOut;

    bit            holdValid;
    logic [W-1:0]  holdData;
    logic [CW-1:0] holdCnt;
    bit            latencyArmed;
    bit            firstSeen;
    int            firstAccept;

    typedef struct {
        string name;
        bit    men;
        int    nIn;
        int    inD [5];
        int    inC [5];
        int    nOut;
        int    outD [5];
        int    outC [5];
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then observe
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [CI-1:0] c,
                                 input logic rdy, output bit accepted);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        s_cnt   = c;
        m_ready = rdy;
        #1;
        if (holdValid) begin
            checkOutput("hold_valid", 64'(m_valid), 64'(1));
            checkOutput("hold_data", 64'(m_data), 64'(holdData));
            checkOutput("hold_cnt", 64'(m_cnt), 64'(holdCnt));
        end
        if (latencyArmed && !firstSeen && m_valid) begin
            firstSeen = 1'b1;
            checkOutput("latency", 64'(cycle - firstAccept), 64'(D + 1));
        end
        accepted = v && s_ready;
        if (s_ready) begin
            posV.push_back(v && (c != '0));
            posD.push_back(int'(d));
            posC.push_back(int'(c));
        end
        if (accepted) begin
            sumIn += longint'(c);
            if (firstAccept < 0) firstAccept = cycle + 1;
        end
        if (m_valid && m_ready) begin
            obsD.push_back(int'(m_data));
            obsC.push_back(int'(m_cnt));
            sumOut += longint'(m_cnt);
        end
        holdValid = m_valid && !m_ready;
        holdData  = m_data;
        holdCnt   = m_cnt;
    endtask

    task automatic resetQueues();
        posV.delete(); posD.delete(); posC.delete();
        obsD.delete(); obsC.delete(); expD.delete(); expC.delete();
        sumIn = 0; sumOut = 0;
        firstAccept = -1; firstSeen = 1'b0;
    endtask

    task automatic flush();
        bit acc;
        repeat (D + 4) applyStimulus(1'b0, '0, '0, 1'b1, acc);
    endtask

    // Reference: walk the entry stream in order; each live head greedily absorbs
    // later same-bin entries within D positions as long as its total fits
    task automatic computeExpected(input bit men);
        int L;
        int total;
        bit alive [];
        L = posV.size();
        alive = new[L];
        for (int p = 0; p < L; p++) alive[p] = posV[p];
        expD.delete(); expC.delete();
        for (int p = 0; p < L; p++) begin
            if (alive[p]) begin
                total = posC[p];
                if (men) begin
                    for (int q = p + 1; q <= p + D && q < L; q++) begin
                        if (alive[q] && posD[q] == posD[p] && total + posC[q] <= CMAX) begin
                            total += posC[q];
                            alive[q] = 1'b0;
                        end
                    end
                end
                expD.push_back(posD[p]);
                expC.push_back(total);
            end
        end
    endtask

    task automatic compareStream(input string tag);
        int n;
        checkOutput({tag, "_count"}, 64'(obsD.size()), 64'(expD.size()));
        n = (obsD.size() < expD.size()) ? obsD.size() : expD.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_data[%0d]", tag, i), 64'(obsD[i]), 64'(expD[i]));
            checkOutput($sformatf("%s_cnt[%0d]", tag, i), 64'(obsC[i]), 64'(expC[i]));
        end
        checkOutput({tag, "_sum"}, 64'(sumOut), 64'(sumIn));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int idx;
        int c;

        vecs[0] = '{"merge_basic", 1'b1, 4, '{5,5,7,5,0}, '{1,1,1,1,0}, 2, '{5,7,0,0,0}, '{3,1,0,0,0}};
        vecs[1] = '{"saturate",    1'b1, 3, '{9,9,9,0,0}, '{8,6,3,0,0}, 2, '{9,9,0,0,0}, '{14,3,0,0,0}};
        vecs[2] = '{"no_merge",    1'b0, 4, '{5,5,7,5,0}, '{1,1,1,1,0}, 4, '{5,5,7,5,0}, '{1,1,1,1,0}};
        vecs[3] = '{"zero_weight", 1'b1, 2, '{3,3,0,0,0}, '{0,2,0,0,0}, 1, '{3,0,0,0,0}, '{2,0,0,0,0}};
        vecs[4] = '{"exact_fit",   1'b1, 4, '{2,2,1,1,0}, '{10,5,15,1,0}, 3, '{2,1,1,0,0}, '{15,15,1,0,0}};
        vecs[5] = '{"window_out",  1'b1, 5, '{4,1,2,3,4}, '{1,1,1,1,1}, 5, '{4,1,2,3,4}, '{1,1,1,1,1}};
        vecs[6] = '{"window_in",   1'b1, 4, '{4,1,2,4,0}, '{1,1,1,1,0}, 3, '{4,1,2,0,0}, '{2,1,1,0,0}};
        vecs[7] = '{"skip_over",   1'b1, 3, '{6,6,6,0,0}, '{9,9,2,0,0}, 2, '{6,6,0,0,0}, '{11,9,0,0,0}};

        rst_n = 1'b0; merge_en = 1'b1; s_valid = 1'b0; s_data = '0; s_cnt = '0; m_ready = 1'b1;
        holdValid = 1'b0; latencyArmed = 1'b0;
        resetQueues();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_m_valid", 64'(m_valid), 64'(0));
        checkOutput("reset_m_data", 64'(m_data), 64'(0));
        checkOutput("reset_m_cnt", 64'(m_cnt), 64'(0));
        checkOutput("reset_s_ready", 64'(s_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        for (int v = 0; v < 8; v++) begin
            merge_en = vecs[v].men;
            resetQueues();
            latencyArmed = (v == 0);
            for (int j = 0; j < vecs[v].nIn; j++) begin
                applyStimulus(1'b1, W'(vecs[v].inD[j]), CI'(vecs[v].inC[j]), 1'b1, acc);
            end
            flush();
            latencyArmed = 1'b0;
            for (int k = 0; k < vecs[v].nOut; k++) begin
                expD.push_back(vecs[v].outD[k]);
                expC.push_back(vecs[v].outC[k]);
            end
            compareStream(vecs[v].name);
        end

        $display("[TB] back-pressure stall");
        merge_en = 1'b1;
        resetQueues();
        idx = 0;
        c = 0;
        while (idx < 10 && c < 100) begin
            applyStimulus(1'b1, W'(idx + 1), CI'(1), !(c >= 6 && c < 11), acc);
            if (c >= 6 && c < 11) checkOutput("stall_s_ready", 64'(s_ready), 64'(0));
            if (acc) idx++;
            c++;
        end
        checkOutput("stall_all_sent", 64'(idx), 64'(10));
        flush();
        expD.delete(); expC.delete();
        for (int k = 1; k <= 10; k++) begin
            expD.push_back(k);
            expC.push_back(1);
        end
        compareStream("stall");

        $display("[TB] randomized traffic");
        for (int ph = 0; ph < 4; ph++) begin
            merge_en = (ph % 2 == 0);
            resetQueues();
            repeat (250) begin
                applyStimulus($urandom_range(0, 9) < 7, W'($urandom_range(0, 3)),
                              CI'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, acc);
            end
            flush();
            computeExpected(merge_en);
            compareStream($sformatf("rand%0d", ph));
        end

        $display("[TB] reset mid-stream");
        merge_en = 1'b1;
        resetQueues();
        for (int j = 0; j < 5; j++) applyStimulus(1'b1, W'(20 + j), CI'(1), 1'b1, acc);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        checkOutput("pre_reset_m_valid", 64'(m_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_m_valid", 64'(m_valid), 64'(0));
        checkOutput("async_reset_m_cnt", 64'(m_cnt), 64'(0));
        checkOutput("async_reset_m_data", 64'(m_data), 64'(0));
        holdValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resetQueues();
        flush();
        checkOutput("post_reset_outputs", 64'(obsD.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
